// File: rtl/ud_seq_pkg.sv
// Shared constants for the up/down step sequencer: FSM state encodings and mode codes.
package ud_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DN     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_AUX    = 2'b11;

endpackage

// File: rtl/ud_step_sequencer_if.sv
// Control/feedback bundle between a sequencer master and the ud_step_sequencer (slave).
interface ud_step_sequencer_if #(parameter int WIDTH = 4);

  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] cnt;
  logic             step;
  logic             ud;
  logic             busy;
  logic             err;
  logic             done;

  modport master (
    output start, stop, mode, lo, hi, cnt,
    input  step, ud, busy, err, done
  );

  modport slave (
    input  start, stop, mode, lo, hi, cnt,
    output step, ud, busy, err, done
  );

endinterface

// File: rtl/ud_seq_prescaler.sv
// Step pacing counter: tick is high for one cycle every PRESCALE enabled cycles.
module ud_seq_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // Free-running 0..PRESCALE-1 counter, restarted when a run begins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (en) begin
      if (r_cnt == LAST) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ud_step_sequencer.sv
// Step/direction sequencer for an up/down counter: free-run up, free-run down, bounce.
// Optional single-sweep mode (mode 11) is compiled in with UD_SEQ_SWEEP_EN.
module ud_step_sequencer
  import ud_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input logic                clk,
  input logic                rst,
  ud_step_sequencer_if.slave bus
);

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_step;
  logic             r_ud;
  logic             r_busy;
  logic             r_err;

  logic [1:0]       w_state_nxt;
  logic             w_step_nxt;
  logic             w_ud_nxt;
  logic             w_err_nxt;
  logic             w_done_nxt;
  logic             w_tick;
  logic             w_run;
  logic             w_accept;

  assign w_run    = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.stop;

  ud_seq_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .en   (w_run),
    .tick (w_tick)
  );

  // Next-state, step and direction decision; turnarounds use the live cnt at step time.
  // Inequalities keep the bounce inside the bounds even if cnt starts outside them.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = 1'b0;
    w_ud_nxt    = r_ud;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_err_nxt = 1'b0;
            case (bus.mode)
              MODE_UP: w_state_nxt = ST_UP;
              MODE_DN: w_state_nxt = ST_DOWN;
              MODE_BOUNCE: begin
                if (bus.lo > bus.hi) begin
                  w_state_nxt = ST_HOLD;
                  w_err_nxt   = 1'b1;
                end else if (bus.cnt < bus.hi) begin
                  w_state_nxt = ST_UP;
                end else begin
                  w_state_nxt = ST_DOWN;
                end
              end
`ifdef UD_SEQ_SWEEP_EN
              default: w_state_nxt = ST_UP;
`else
              default: w_state_nxt = ST_HOLD;
`endif
            endcase
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_UP: begin
          if (w_tick) begin
            if ((r_mode == MODE_BOUNCE) && (bus.cnt >= r_hi)) begin
              w_step_nxt  = 1'b1;
              w_ud_nxt    = 1'b1;
              w_state_nxt = ST_DOWN;
`ifdef UD_SEQ_SWEEP_EN
            end else if ((r_mode == MODE_AUX) && (bus.cnt >= r_hi)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
`endif
            end else begin
              w_step_nxt = 1'b1;
              w_ud_nxt   = 1'b0;
            end
          end else begin
            w_state_nxt = ST_UP;
          end
        end
        ST_DOWN: begin
          if (w_tick) begin
            if ((r_mode == MODE_BOUNCE) && (bus.cnt <= r_lo)) begin
              w_step_nxt  = 1'b1;
              w_ud_nxt    = 1'b0;
              w_state_nxt = ST_UP;
            end else begin
              w_step_nxt = 1'b1;
              w_ud_nxt   = 1'b1;
            end
          end else begin
            w_state_nxt = ST_DOWN;
          end
        end
        ST_HOLD: w_state_nxt = ST_HOLD;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, latched run configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'b00;
      r_lo    <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_step  <= 1'b0;
      r_ud    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_ud    <= w_ud_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_mode <= bus.mode;
        r_lo   <= bus.lo;
        r_hi   <= bus.hi;
      end else begin
        r_mode <= r_mode;
        r_lo   <= r_lo;
        r_hi   <= r_hi;
      end
    end
  end

`ifdef UD_SEQ_SWEEP_EN
  logic r_done;

  // Sweep completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
    end
  end

  assign bus.done = r_done;
`else
  logic w_done_unused;
  assign w_done_unused = w_done_nxt;
  assign bus.done      = 1'b0;
`endif

  assign bus.step = r_step;
  assign bus.ud   = r_ud;
  assign bus.busy = r_busy;
  assign bus.err  = r_err;

endmodule
